// File: rtl/spi_readback.sv
// SPI read responder: serves host read frames by streaming SRAM words out on MISO
// (MSB-first, auto-incrementing address, one-word prefetch).
module spi_readback #(
  parameter int unsigned              ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned              DATA_BUS_WIDTH    = 16,
  parameter int unsigned              COMMAND_WIDTH     = 8,
  parameter logic [COMMAND_WIDTH-1:0] READ_COMMAND      = 8'h03
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cs,
  input  logic                         sck,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         miso_oe,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic                         read_request,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  input  logic                         read_finished_strobe,
  output logic                         underrun
);

  localparam int unsigned AW         = ADDRESS_BUS_WIDTH;
  localparam int unsigned DW         = DATA_BUS_WIDTH;
  localparam int unsigned CW         = COMMAND_WIDTH;
  localparam int unsigned SH_W       = (AW > CW) ? AW : CW;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  logic [1:0]      r_cs_sync, r_sck_sync, r_mosi_sync;
  logic            r_cs_d, r_sck_d;
  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SH_W-2:0] r_sh_in;
  logic [DW-1:0]   r_shift;
  logic            r_load_pend;
  logic            r_oe;
  logic            r_underrun;
  logic            r_req;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_base;
  logic            r_stale;
  logic            r_fetch_en;
  logic            r_first;
  logic            r_pf_valid;
  logic [DW-1:0]   r_pf_data;

  logic            w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall, w_mosi;
  logic [SH_W-1:0] w_sh_next;
  logic [CW-1:0]   w_cmd;
  logic [AW-1:0]   w_addr;
  logic            w_start, w_load, w_strobe_hit, w_capture, w_load_underrun;
  logic [DW-1:0]   w_load_word;

  // Two-flop synchronisers plus delayed copies for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_sync   <= 2'b11;
      r_sck_sync  <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_d      <= 1'b1;
      r_sck_d     <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], cs};
      r_sck_sync  <= {r_sck_sync[0], sck};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_cs_d      <= r_cs_sync[1];
      r_sck_d     <= r_sck_sync[1];
    end
  end

  assign w_cs_fall  = r_cs_d & ~r_cs_sync[1];
  assign w_cs_rise  = ~r_cs_d & r_cs_sync[1];
  assign w_sck_rise = ~r_sck_d & r_sck_sync[1];
  assign w_sck_fall = r_sck_d & ~r_sck_sync[1];
  assign w_mosi     = r_mosi_sync[1];

  assign w_sh_next = {r_sh_in, w_mosi};
  assign w_cmd     = w_sh_next[CW-1:0];
  assign w_addr    = w_sh_next[AW-1:0];

  assign w_start = (r_state == S_ADDR) && w_sck_rise && !w_cs_rise &&
                   (r_cnt == CNT_W'(AW - 1));
  assign w_load  = ((r_state == S_DUMMY) || (r_state == S_DATA)) &&
                   r_load_pend && w_sck_fall && !w_cs_rise;

  // A strobe only belongs to us while our request is up; stale data is dropped
  assign w_strobe_hit    = read_finished_strobe & r_req;
  assign w_capture       = w_strobe_hit & ~r_stale;
  assign w_load_word     = w_capture ? read_data : (r_pf_valid ? r_pf_data : '0);
  assign w_load_underrun = ~w_capture & ~r_pf_valid;

  // Frame sequencer: command/address decode, dummy phase and MISO shifting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sh_in     <= '0;
      r_shift     <= '0;
      r_load_pend <= 1'b0;
      r_oe        <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (w_cs_rise) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_load_pend <= 1'b0;
      r_oe        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= S_CMD;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_underrun <= 1'b0;
          end
        end
        S_CMD: begin
          if (w_sck_rise) begin
            r_sh_in <= w_sh_next[SH_W-2:0];
            if (r_cnt == CNT_W'(CW - 1)) begin
              r_cnt   <= '0;
              r_state <= (w_cmd == READ_COMMAND) ? S_ADDR : S_IGNORE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_ADDR: begin
          if (w_sck_rise) begin
            r_sh_in <= w_sh_next[SH_W-2:0];
            if (w_start) begin
              r_cnt   <= '0;
              r_state <= S_DUMMY;
              r_oe    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DUMMY: begin
          if (w_sck_rise) begin
            if (r_cnt == CNT_W'(DUMMY_BITS - 1)) begin
              r_cnt       <= '0;
              r_load_pend <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          if (w_load) begin
            r_state     <= S_DATA;
            r_shift     <= w_load_word;
            r_load_pend <= 1'b0;
            if (w_load_underrun) r_underrun <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_sck_rise) begin
            if (r_cnt == CNT_W'(DW - 1)) begin
              r_cnt       <= '0;
              r_load_pend <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          if (w_load) begin
            r_shift     <= w_load_word;
            r_load_pend <= 1'b0;
            if (w_load_underrun) r_underrun <= 1'b1;
          end else if (w_sck_fall) begin
            r_shift <= {r_shift[DW-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM fetch engine: single outstanding request, one-word prefetch buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_base     <= '0;
      r_stale    <= 1'b0;
      r_fetch_en <= 1'b0;
      r_first    <= 1'b0;
      r_pf_valid <= 1'b0;
      r_pf_data  <= '0;
    end else begin
      if (w_strobe_hit) begin
        r_req   <= 1'b0;
        r_stale <= 1'b0;
        if (!r_stale) begin
          r_addr <= r_addr + AW'(1);
          if (!w_load) begin
            r_pf_data  <= read_data;
            r_pf_valid <= 1'b1;
          end
        end
      end
      if (w_load) r_pf_valid <= 1'b0;
      if (w_cs_rise) begin
        r_fetch_en <= 1'b0;
        r_first    <= 1'b0;
        r_pf_valid <= 1'b0;
        if (r_req && !read_finished_strobe) r_stale <= 1'b1;
      end else if (w_start) begin
        r_fetch_en <= 1'b1;
        if (r_req) begin
          // previous frame's request still in flight: defer the first fetch
          r_first <= 1'b1;
          r_base  <= w_addr;
        end else begin
          r_req  <= 1'b1;
          r_addr <= w_addr;
        end
      end else if (r_fetch_en && !r_req && !r_pf_valid) begin
        r_req <= 1'b1;
        if (r_first) begin
          r_addr  <= r_base;
          r_first <= 1'b0;
        end
      end
    end
  end

  assign miso         = r_shift[DW-1];
  assign miso_oe      = r_oe;
  assign read_address = r_addr;
  assign read_request = r_req;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_spi_readback.sv
// Directed bench for spi_readback with a small SRAM responder of programmable latency.
module tb_spi_readback;

  logic        clk = 1'b0;
  logic        rst, cs, sck, mosi;
  logic        miso, miso_oe;
  logic [15:0] read_address;
  logic        read_request;
  logic [15:0] read_data;
  logic        read_finished_strobe;
  logic        underrun;

  int n_checks = 0;
  int n_err    = 0;

  // SRAM responder state
  int          lat_first, lat_rest, req_idx, cnt, addr_glitch;
  logic        busy;
  logic [15:0] busy_addr;
  logic [15:0] log_addr[$];
  logic        oe_seen;

  spi_readback dut (
    .clk                  (clk),
    .rst                  (rst),
    .cs                   (cs),
    .sck                  (sck),
    .mosi                 (mosi),
    .miso                 (miso),
    .miso_oe              (miso_oe),
    .read_address         (read_address),
    .read_request         (read_request),
    .read_data            (read_data),
    .read_finished_strobe (read_finished_strobe),
    .underrun             (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: mem_word = 16'hA5C3;
      16'h0011: mem_word = 16'h1234;
      16'hFFFF: mem_word = 16'hBEEF;
      16'h0000: mem_word = 16'hCAFE;
      default:  mem_word = a ^ 16'h5A5A;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One SPI mode-0 bit at clk/8; MISO sampled just before the rising edge
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    tick(4);
    m = miso;
    oe_seen = oe_seen | miso_oe;
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic spi_xfer(input logic [31:0] tx, input int n, output logic [31:0] rx);
    logic m;
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx = {rx[30:0], m};
    end
  endtask

  task automatic spi_begin();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic spi_end();
    tick(4);
    cs = 1'b1;
    tick(8);
  endtask

  task automatic read2(input logic [15:0] a, output logic [15:0] w0, output logic [15:0] w1);
    logic [31:0] rx;
    spi_begin();
    spi_xfer(32'h03, 8, rx);
    spi_xfer({16'h0, a}, 16, rx);
    spi_xfer(32'h0, 8, rx);
    spi_xfer(32'h0, 16, rx);
    w0 = rx[15:0];
    spi_xfer(32'h0, 16, rx);
    w1 = rx[15:0];
    spi_end();
  endtask

  task automatic new_test(input int lf, input int lr);
    tick(20);
    lat_first = lf;
    lat_rest  = lr;
    req_idx   = 0;
    log_addr.delete();
    oe_seen   = 1'b0;
  endtask

  // SRAM model: latches the address when a request appears, strobes after a latency
  initial begin
    read_finished_strobe = 1'b0;
    read_data   = 16'hDEAD;
    busy        = 1'b0;
    cnt         = 0;
    addr_glitch = 0;
    busy_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || !read_request) begin
        busy = 1'b0;
        read_finished_strobe = 1'b0;
        read_data = 16'hDEAD;
      end else if (!busy) begin
        busy      = 1'b1;
        busy_addr = read_address;
        log_addr.push_back(read_address);
        cnt = (req_idx == 0) ? lat_first : lat_rest;
        req_idx++;
      end else begin
        if (read_address !== busy_addr) addr_glitch++;
        if (cnt <= 1) begin
          read_data = mem_word(busy_addr);
          read_finished_strobe = 1'b1;
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    logic [15:0] w0, w1;
    logic [31:0] rx;
    rst = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    lat_first = 4; lat_rest = 4; req_idx = 0; oe_seen = 1'b0;

    // Reset held, then released
    tick(3);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_oe", 32'(miso_oe), 32'h0);
    check("rst_req", 32'(read_request), 32'h0);
    check("rst_addr", 32'(read_address), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    rst = 1'b1;
    tick(3);
    check("rel_oe", 32'(miso_oe), 32'h0);
    check("rel_req", 32'(read_request), 32'h0);
    check("rel_addr", 32'(read_address), 32'h0);

    // Basic two-word read from 0x0010
    new_test(4, 4);
    read2(16'h0010, w0, w1);
    check("basic_w0", 32'(w0), 32'h0000A5C3);
    check("basic_w1", 32'(w1), 32'h00001234);
    check("basic_a0", 32'(log_addr[0]), 32'h0010);
    check("basic_a1", 32'(log_addr[1]), 32'h0011);
    check("basic_a2", 32'(log_addr[2]), 32'h0012);
    check("basic_underrun", 32'(underrun), 32'h0);
    check("basic_oe_seen", 32'(oe_seen), 32'h1);
    check("basic_oe_after", 32'(miso_oe), 32'h0);
    check("basic_miso_after", 32'(miso), 32'h0);

    // Address wrap 0xFFFF -> 0x0000
    new_test(4, 4);
    read2(16'hFFFF, w0, w1);
    check("wrap_w0", 32'(w0), 32'h0000BEEF);
    check("wrap_w1", 32'(w1), 32'h0000CAFE);
    check("wrap_a0", 32'(log_addr[0]), 32'hFFFF);
    check("wrap_a1", 32'(log_addr[1]), 32'h0000);
    check("wrap_underrun", 32'(underrun), 32'h0);

    // Slow bus: second fetch misses its word boundary
    new_test(4, 200);
    read2(16'h0010, w0, w1);
    check("slow_w0", 32'(w0), 32'h0000A5C3);
    check("slow_w1", 32'(w1), 32'h00000000);
    check("slow_underrun", 32'(underrun), 32'h1);
    tick(250);
    check("slow_sticky", 32'(underrun), 32'h1);
    cs = 1'b0;
    tick(4);
    check("slow_cleared", 32'(underrun), 32'h0);
    cs = 1'b1;
    tick(8);

    // Non-read command 0x02 for 40 bits
    new_test(4, 4);
    spi_begin();
    spi_xfer(32'h02, 8, rx);
    spi_xfer(32'h12345678, 32, rx);
    check("wr_miso", rx, 32'h0);
    check("wr_oe_seen", 32'(oe_seen), 32'h0);
    check("wr_req", 32'(read_request), 32'h0);
    spi_end();
    check("wr_nreq", log_addr.size(), 0);

    // Abort with an outstanding request, then an immediate new frame
    new_test(240, 4);
    spi_begin();
    spi_xfer(32'h03, 8, rx);
    spi_xfer(32'h0040, 16, rx);
    tick(4);
    cs = 1'b1;
    tick(4);
    check("abort_oe", 32'(miso_oe), 32'h0);
    check("abort_req_held", 32'(read_request), 32'h1);
    tick(4);
    spi_begin();
    spi_xfer(32'h03, 8, rx);
    spi_xfer(32'h0080, 16, rx);
    tick(2);
    check("abort_old_req", 32'(read_request), 32'h1);
    check("abort_old_addr", 32'(read_address), 32'h0040);
    spi_xfer(32'h0, 8, rx);
    spi_xfer(32'h0, 16, rx);
    w0 = rx[15:0];
    spi_xfer(32'h0, 16, rx);
    w1 = rx[15:0];
    spi_end();
    check("abort_w0", 32'(w0), 32'h00005ADA);
    check("abort_w1", 32'(w1), 32'h00005ADB);
    check("abort_a0", 32'(log_addr[0]), 32'h0040);
    check("abort_a1", 32'(log_addr[1]), 32'h0080);
    check("abort_a2", 32'(log_addr[2]), 32'h0081);
    check("abort_underrun", 32'(underrun), 32'h0);
    check("addr_stable", addr_glitch, 0);

    // Reset asserted in the middle of a data phase
    new_test(200, 200);
    spi_begin();
    spi_xfer(32'h03, 8, rx);
    spi_xfer(32'h0010, 16, rx);
    spi_xfer(32'h0, 8, rx);
    spi_xfer(32'h0, 4, rx);
    check("mid_req_before", 32'(read_request), 32'h1);
    check("mid_oe_before", 32'(miso_oe), 32'h1);
    check("mid_underrun_before", 32'(underrun), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_req_async", 32'(read_request), 32'h0);
    check("mid_oe_async", 32'(miso_oe), 32'h0);
    cs = 1'b1;
    sck = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    check("mid_miso", 32'(miso), 32'h0);
    check("mid_addr", 32'(read_address), 32'h0);
    check("mid_underrun", 32'(underrun), 32'h0);
    check("mid_req", 32'(read_request), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
